io_control: RTL

- Memory-mapped IO controller for the 3-stage RISC-V core. Serves every data access whose upper address nibble selects IO (0x8).
- Sequences UART traffic through small TX/RX FIFOs with ready/valid handshakes on the UART side.
- Maintains cycle and retired-instruction counters for software.
- Sits beside data/BIOS memories; its registered read data joins the load mux when the memory-map decoder selects IO.

---
 rtl/io_control.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/io_control.sv
// io_control: memory-mapped IO block with UART TX/RX FIFOs and cycle/retired-instruction counters.
// Define IO_BRANCH_CNT_EN to add the branch (0x1C) and taken-branch (0x20) counters.
module io_control #(
   parameter int unsigned TX_DEPTH = 4,
   parameter int unsigned RX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_en,
   input  logic        io_re,
   input  logic [3:0]  wea,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        inst_retire,
   input  logic        branch_taken,
   input  logic        branch_retire,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready
);
   localparam int unsigned TXA = $clog2(TX_DEPTH);
   localparam int unsigned RXA = $clog2(RX_DEPTH);
   localparam logic [TXA:0] TX_ONE = {{TXA{1'b0}}, 1'b1};
   localparam logic [RXA:0] RX_ONE = {{RXA{1'b0}}, 1'b1};

   localparam logic [7:0] A_STATUS = 8'h00;
   localparam logic [7:0] A_RXDATA = 8'h04;
   localparam logic [7:0] A_TXDATA = 8'h08;
   localparam logic [7:0] A_CYCLE  = 8'h10;
   localparam logic [7:0] A_INST   = 8'h14;
   localparam logic [7:0] A_CNTRST = 8'h18;
`ifdef IO_BRANCH_CNT_EN
   localparam logic [7:0] A_BRANCH = 8'h1C;
   localparam logic [7:0] A_TAKEN  = 8'h20;
`endif

   logic load, store, cnt_clr;
   assign load    = io_en & io_re & (wea == 4'b0000);
   assign store   = io_en & (|wea);
   assign cnt_clr = store & (addr[7:0] == A_CNTRST);

   logic [7:0]   tx_mem_q [TX_DEPTH];
   logic [TXA:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic         tx_empty, tx_full, tx_push, tx_pop;

   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = (tx_wr_q[TXA] != tx_rd_q[TXA]) && (tx_wr_q[TXA-1:0] == tx_rd_q[TXA-1:0]);
   assign tx_push  = store & (addr[7:0] == A_TXDATA) & ~tx_full;
   assign tx_pop   = ~tx_empty & uart_tx_ready;

   assign uart_tx_valid = ~tx_empty;
   assign uart_tx_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q[TXA-1:0]];

   always_comb begin
      tx_wr_d = tx_wr_q;
      tx_rd_d = tx_rd_q;
      if (tx_push) tx_wr_d = tx_wr_q + TX_ONE;
      if (tx_pop)  tx_rd_d = tx_rd_q + TX_ONE;
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_q[TXA-1:0]] <= wdata[7:0];
   end

   logic [7:0]   rx_mem_q [RX_DEPTH];
   logic [RXA:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic         rx_empty, rx_full, rx_push, rx_pop;
   logic [7:0]   rx_head;

   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = (rx_wr_q[RXA] != rx_rd_q[RXA]) && (rx_wr_q[RXA-1:0] == rx_rd_q[RXA-1:0]);
   assign rx_push  = uart_rx_valid & ~rx_full;
   assign rx_pop   = load & (addr[7:0] == A_RXDATA) & ~rx_empty;
   assign rx_head  = rx_empty ? '0 : rx_mem_q[rx_rd_q[RXA-1:0]];

   assign uart_rx_ready = ~rx_full;

   always_comb begin
      rx_wr_d = rx_wr_q;
      rx_rd_d = rx_rd_q;
      if (rx_push) rx_wr_d = rx_wr_q + RX_ONE;
      if (rx_pop)  rx_rd_d = rx_rd_q + RX_ONE;
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wr_q[RXA-1:0]] <= uart_rx_data;
   end

   logic [31:0] cycle_q, cycle_d, inst_q, inst_d;

   always_comb begin
      cycle_d = cycle_q + 32'd1;
      inst_d  = inst_retire ? inst_q + 32'd1 : inst_q;
      if (cnt_clr) begin
         cycle_d = '0;
         inst_d  = '0;
      end
   end

`ifdef IO_BRANCH_CNT_EN
   logic [31:0] branch_q, branch_d, taken_q, taken_d;

   always_comb begin
      branch_d = branch_retire ? branch_q + 32'd1 : branch_q;
      taken_d  = (branch_retire & branch_taken) ? taken_q + 32'd1 : taken_q;
      if (cnt_clr) begin
         branch_d = '0;
         taken_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_q <= '0;
         taken_q  <= '0;
      end else begin
         branch_q <= branch_d;
         taken_q  <= taken_d;
      end
   end
`else
   logic unused_branch;
   assign unused_branch = branch_taken ^ branch_retire;
`endif

   logic unused_bits;
   assign unused_bits = ^{addr[31:8], wdata[31:8]};

   // Counters are read before this edge's increment, so the mux uses the _q values.
   logic [31:0] rd_mux, rdata_q, rdata_d;

   always_comb begin
      rd_mux = '0;
      case (addr[7:0])
         A_STATUS: rd_mux = {30'b0, ~rx_empty, ~tx_full};
         A_RXDATA: rd_mux = {24'b0, rx_head};
         A_CYCLE:  rd_mux = cycle_q;
         A_INST:   rd_mux = inst_q;
`ifdef IO_BRANCH_CNT_EN
         A_BRANCH: rd_mux = branch_q;
         A_TAKEN:  rd_mux = taken_q;
`endif
         default:  rd_mux = '0;
      endcase
      rdata_d = load ? rd_mux : rdata_q;
   end

   assign rdata = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_q <= '0;
         tx_rd_q <= '0;
         rx_wr_q <= '0;
         rx_rd_q <= '0;
         cycle_q <= '0;
         inst_q  <= '0;
         rdata_q <= '0;
      end else begin
         tx_wr_q <= tx_wr_d;
         tx_rd_q <= tx_rd_d;
         rx_wr_q <= rx_wr_d;
         rx_rd_q <= rx_rd_d;
         cycle_q <= cycle_d;
         inst_q  <= inst_d;
         rdata_q <= rdata_d;
      end
   end
endmodule
